mvm_result_streamer: RTL and testbench

//  Drains the result vector y out of the matrix-vector multiplier's y memory after a compute pass completes.

---
 rtl/mvm_pkg.sv | 17 +
 rtl/mvm_skid_fifo.sv | 47 ++++
 rtl/mvm_result_streamer.sv | 133 +++++++++++++
 tb/tb_mvm_result_streamer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared defaults and state encoding for the matrix-vector multiplier result path.
`timescale 1ns/1ps
package mvm_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_Y_SIZE     = 3;
    localparam int DEF_LOGSIZE    = 2;

    // Result streamer pass sequencing.
    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } stream_state_t;

endpackage

// File: rtl/mvm_skid_fifo.sv
// Two-entry synchronous FIFO that absorbs sink backpressure between the
// y memory read port and the output stream. Each entry is {last, data}.
// The caller never pushes when full and never pops when empty.
`timescale 1ns/1ps
module mvm_skid_fifo #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    // Storage, pointers and occupancy; a simultaneous push and pop leaves occ unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/mvm_result_streamer.sv
// Drains the y result memory onto a valid/ready stream after a compute pass.
//
// Output handshake: a word transfers on any cycle where out_valid & out_ready.
// Once out_valid rises it stays high, with out_data/out_last stable, until
// that transfer happens; out_ready while out_valid is low does nothing.
//
// Reads are throttled so that buffered words plus the read still in flight
// never exceed the two buffer slots, which lets the stream run one word per
// cycle with an always-ready sink and stall cleanly otherwise.
`timescale 1ns/1ps
module mvm_result_streamer
    import mvm_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int Y_SIZE     = DEF_Y_SIZE,
    parameter int LOGSIZE    = DEF_LOGSIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  rd_en_y,
    output logic [LOGSIZE-1:0]    rd_addr_y,
    input  logic [DATA_WIDTH-1:0] rd_data_y,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  drained,
    output stream_state_t         state_dbg
);

    localparam logic [LOGSIZE-1:0] LAST_ADDR = LOGSIZE'(Y_SIZE - 1);

    stream_state_t           state;
    stream_state_t           state_next;
    logic                    inflight;
    logic                    inflight_last;
    logic [1:0]              occ;
    logic [DATA_WIDTH:0]     head;
    logic                    pop;
    logic                    at_last;
    logic                    start_accept;
    logic [2:0]              level;

    mvm_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data ({inflight_last, rd_data_y}),
        .pop       (pop),
        .occ       (occ),
        .head      (head)
    );

    assign out_valid = (occ != 2'd0);
    assign out_data  = head[DATA_WIDTH-1:0];
    assign out_last  = head[DATA_WIDTH] & out_valid;
    assign pop       = out_valid & out_ready;

    // Slots that will be occupied after this cycle settles, before any new read.
    assign level     = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign rd_en_y   = (state == S_FETCH) && (level < 3'd2);
    assign at_last   = (rd_addr_y == LAST_ADDR);

    assign start_accept = start && ((state == S_IDLE) || (state == S_DONE));
    assign state_dbg    = state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        drained    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                busy = 1'b1;
                if (rd_en_y && at_last) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (pop && out_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                drained    = 1'b1;
                state_next = start ? S_FETCH : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Read address: restarts on an accepted start, holds at the final element.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_y <= '0;
        end else if (start_accept) begin
            rd_addr_y <= '0;
        end else if (rd_en_y && !at_last) begin
            rd_addr_y <= rd_addr_y + LOGSIZE'(1);
        end
    end

    // Tracks the read whose data lands next cycle and whether it is the last element.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= rd_en_y;
            inflight_last <= rd_en_y && at_last;
        end
    end

endmodule

// File: tb/tb_mvm_result_streamer.sv
// Bench for the y result streamer: directed timing traces plus randomized
// passes checked by a scoreboard fed from a pass-level reference model.
`timescale 1ns/1ps
module tb_mvm_result_streamer;
    import mvm_pkg::*;

    localparam int DW = 16;
    localparam int YS = 3;
    localparam int LS = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Main instance (Y_SIZE=3)
    logic          start;
    logic          rd_en_y;
    logic [LS-1:0] rd_addr_y;
    logic [DW-1:0] rd_data_y;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          drained;
    stream_state_t state_dbg;

    // Single-element instance (Y_SIZE=1)
    logic          start_1;
    logic          rd_en_1;
    logic [0:0]    rd_addr_1;
    logic [DW-1:0] rd_data_1;
    logic [DW-1:0] out_data_1;
    logic          out_valid_1;
    logic          out_ready_1;
    logic          out_last_1;
    logic          busy_1;
    logic          drained_1;
    stream_state_t state_dbg_1;

    mvm_result_streamer #(.DATA_WIDTH(DW), .Y_SIZE(YS), .LOGSIZE(LS)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rd_en_y(rd_en_y), .rd_addr_y(rd_addr_y), .rd_data_y(rd_data_y),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .drained(drained), .state_dbg(state_dbg)
    );

    mvm_result_streamer #(.DATA_WIDTH(DW), .Y_SIZE(1), .LOGSIZE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start_1),
        .rd_en_y(rd_en_1), .rd_addr_y(rd_addr_1), .rd_data_y(rd_data_1),
        .out_data(out_data_1), .out_valid(out_valid_1), .out_ready(out_ready_1),
        .out_last(out_last_1), .busy(busy_1), .drained(drained_1), .state_dbg(state_dbg_1)
    );

    // ---------------- y memory models (1-cycle read latency, garbage otherwise) ----------------
    logic [DW-1:0] y_mem [4];

    always @(posedge clk) begin
        if (rd_en_y) rd_data_y <= y_mem[rd_addr_y];
        else         rd_data_y <= DW'($urandom);
    end

    always @(posedge clk) begin
        if (rd_en_1) rd_data_1 <= 16'hBEEF;
        else         rd_data_1 <= DW'($urandom);
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [DW:0] exp_q[$];
    logic        mon_en = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        prev_stall = 1'b0;
    logic [DW:0] prev_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare stream and status against the pass-level model every cycle.
    always @(negedge clk) begin
        logic [DW:0] w;
        logic        hs;
        logic        last_hs;
        if (mon_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("drained", 32'(drained), 32'(m_done));
            if (rd_en_y) check("rd_addr_range", 32'(int'(rd_addr_y) < YS), 32'd1);
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_word", 32'({out_last, out_data}), 32'(prev_word));
            end
            if (exp_q.size() == 0) check("spurious_valid", 32'(out_valid), 32'd0);
            hs      = out_valid && out_ready && !reset;
            last_hs = 1'b0;
            if (hs && exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check("word", 32'({out_last, out_data}), 32'(w));
                last_hs = w[DW];
            end
            prev_stall = out_valid && !out_ready && !reset;
            prev_word  = {out_last, out_data};
            if (reset) begin
                m_busy = 1'b0;
                m_done = 1'b0;
                exp_q.delete();
            end else begin
                m_done = m_busy && last_hs;
                if (m_busy) begin
                    m_busy = !last_hs;
                end else if (start) begin
                    m_busy = 1'b1;
                    for (int i = 0; i < YS; i++) exp_q.push_back({(i == YS - 1), y_mem[i]});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic wait_drained(input int bound);
        int n = 0;
        while (drained !== 1'b1 && n < bound) begin
            @(posedge clk); #1; n++;
        end
        check("drained_timeout", 32'(n < bound), 32'd1);
    endtask

    // mode 0: always ready, 1: toggling, 2: random. noise adds stray start pulses.
    task automatic run_pass(input int mode, input bit noise);
        int n = 0;
        @(posedge clk); #1; start = 1'b1;
        out_ready = (mode == 1) ? 1'b1 : (mode == 0 ? 1'b1 : 1'($urandom_range(0, 1)));
        @(posedge clk); #1; start = 1'b0;
        while (drained !== 1'b1 && n < 200) begin
            if (mode == 0)      out_ready = 1'b1;
            else if (mode == 1) out_ready = ~out_ready;
            else                out_ready = ($urandom_range(0, 3) != 0);
            start = noise && ($urandom_range(0, 4) == 0);
            @(posedge clk); #1; n++;
        end
        start = 1'b0;
        check("pass_timeout", 32'(n < 200), 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] trace [6];
        logic [3:0] trace1 [4];
        int cnt;
        trace  = '{4'b1010, 4'b1010, 4'b1110, 4'b0110, 4'b0110, 4'b0001};
        trace1 = '{4'b1010, 4'b0010, 4'b0110, 4'b0001};

        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        start_1 = 1'b0; out_ready_1 = 1'b1;
        y_mem = '{16'h0011, 16'h0022, 16'h0033, 16'h0000};
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'({rd_en_y, rd_addr_y, out_valid, out_data, out_last, busy, drained}), 32'd0);
        check("reset_state", 32'(state_dbg), 32'(S_IDLE));
        check("reset_outputs_1", 32'({rd_en_1, out_valid_1, out_last_1, busy_1, drained_1}), 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        // Directed: ready always high, cycle-exact trace.
        out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("trace_%0d", i + 1), 32'({rd_en_y, out_valid, busy, drained}), 32'(trace[i]));
            if (i < 3) check($sformatf("trace_addr_%0d", i + 1), 32'(rd_addr_y), i);
            if (i == 4) check("trace_last", 32'(out_last), 32'd1);
        end
        repeat (2) @(posedge clk);

        // Directed: sink stalled; only two reads may be issued.
        #1; out_ready = 1'b0;
        pulse_start();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rd_en_y) cnt++;
        end
        check("stall_reads", 32'(cnt), 32'd2);
        @(posedge clk); #1; out_ready = 1'b1;
        wait_drained(50);
        check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

        // Directed: toggling ready.
        run_pass(1, 1'b0);

        // Directed: start mid-pass is ignored.
        out_ready = 1'b1;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_drained(50);
        @(posedge clk); #1;
        check("midpass_start_idle", 32'(busy), 32'd0);

        // Directed: start in the DONE cycle begins a new pass right away.
        run_pass(0, 1'b0);
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        check("done_restart_busy", 32'(busy), 32'd1);
        wait_drained(50);

        // Directed: reset mid-pass, then a fresh pass.
        repeat (2) @(posedge clk);
        #1;
        pulse_start();
        repeat (3) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        check("midreset_outputs", 32'({out_valid, busy, rd_en_y, drained}), 32'd0);
        run_pass(0, 1'b0);

        // Randomized passes with random data, backpressure and stray starts.
        for (int p = 0; p < 25; p++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            for (int i = 0; i < YS; i++) y_mem[i] = DW'($urandom);
            run_pass(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
        repeat (3) @(posedge clk);

        // Single-element build.
        #1; start_1 = 1'b1;
        @(posedge clk); #1; start_1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("ys1_trace_%0d", i + 1), 32'({rd_en_1, out_valid_1, busy_1, drained_1}), 32'(trace1[i]));
            if (i == 0) check("ys1_addr", 32'(rd_addr_1), 32'd0);
            if (i == 2) check("ys1_word", 32'({out_last_1, out_data_1}), 32'h1BEEF);
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
